// File: rtl/player_ctrl.sv
// Player position/animation controller: samples direction keys during stage
// states, moves on a divided tick with clamping, and steps a 4-phase walk cycle.
module player_ctrl #(
  parameter int MOVE_DIV = 1000000,
  parameter int ANIM_DIV = 10000000,
  parameter int STEP     = 1,
  parameter int START_X  = 10,
  parameter int START_Y  = 10,
  parameter int X_MAX    = 310,
  parameter int Y_MAX    = 230
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [3:0] player_state,
  output logic       moving
);

  localparam logic [3:0] ST_TITLE  = 4'd0;
  localparam logic [3:0] ST_STAGE1 = 4'd2;
  localparam logic [3:0] ST_STAGE2 = 4'd4;
  localparam logic [3:0] ST_STAGE3 = 4'd6;

  localparam int MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_DIV - 1);
  localparam logic [ACW-1:0] ANIM_LAST = ACW'(ANIM_DIV - 1);

  localparam logic [9:0] STEP10  = 10'(STEP);
  localparam logic [9:0] XMAX10  = 10'(X_MAX);
  localparam logic [9:0] YMAX10  = 10'(Y_MAX);
  localparam logic [8:0] SPAWN_X = 9'(START_X);
  localparam logic [8:0] SPAWN_Y = 9'(START_Y);

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  logic [8:0]     x_reg, x_next;
  logic [8:0]     y_reg, y_next;
  dir_t           dir_reg, dir_next;
  logic [1:0]     phase_reg, phase_next;
  logic           moving_reg, moving_next;
  logic [MCW-1:0] move_cnt_reg, move_cnt_next;
  logic [ACW-1:0] anim_cnt_reg, anim_cnt_next;
  logic [3:0]     prev_state_reg;

  logic       in_stage;
  logic       respawn;
  logic       move_tick;
  logic       anim_tick;
  logic       key_valid;
  dir_t       key_dir;
  logic [9:0] x_ext;
  logic [9:0] y_ext;

  assign in_stage  = (state == ST_STAGE1) || (state == ST_STAGE2) || (state == ST_STAGE3);
  assign respawn   = in_stage && (state != prev_state_reg);
  assign move_tick = in_stage && (move_cnt_reg == MOVE_LAST);
  assign anim_tick = in_stage && (anim_cnt_reg == ANIM_LAST);
  assign key_valid = key_up || key_down || key_left || key_right;
  assign x_ext     = {1'b0, x_reg};
  assign y_ext     = {1'b0, y_reg};

  // Fixed priority up > down > left > right when several keys are held.
  always_comb begin
    key_dir = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
  end

  always_comb begin
    x_next        = x_reg;
    y_next        = y_reg;
    dir_next      = dir_reg;
    phase_next    = phase_reg;
    moving_next   = in_stage && key_valid;
    move_cnt_next = (move_cnt_reg == MOVE_LAST) ? '0 : move_cnt_reg + 1'b1;
    anim_cnt_next = (anim_cnt_reg == ANIM_LAST) ? '0 : anim_cnt_reg + 1'b1;

    if (!in_stage || respawn) begin
      move_cnt_next = '0;
      anim_cnt_next = '0;
    end

    if (respawn) begin
      x_next     = SPAWN_X;
      y_next     = SPAWN_Y;
      dir_next   = DIR_DOWN;
      phase_next = 2'd0;
    end else if (in_stage) begin
      if (move_tick && key_valid) begin
        dir_next = key_dir;
        // Saturating steps in 10 bits so neither direction can wrap.
        unique case (key_dir)
          DIR_UP:    y_next = (y_ext < STEP10) ? 9'd0 : 9'(y_ext - STEP10);
          DIR_DOWN:  y_next = (y_ext + STEP10 > YMAX10) ? 9'(YMAX10) : 9'(y_ext + STEP10);
          DIR_LEFT:  x_next = (x_ext < STEP10) ? 9'd0 : 9'(x_ext - STEP10);
          DIR_RIGHT: x_next = (x_ext + STEP10 > XMAX10) ? 9'(XMAX10) : 9'(x_ext + STEP10);
        endcase
      end
      if (anim_tick) begin
        phase_next = moving_reg ? phase_reg + 2'd1 : 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg          <= SPAWN_X;
      y_reg          <= SPAWN_Y;
      dir_reg        <= DIR_DOWN;
      phase_reg      <= 2'd0;
      moving_reg     <= 1'b0;
      move_cnt_reg   <= '0;
      anim_cnt_reg   <= '0;
      prev_state_reg <= ST_TITLE;
    end else begin
      x_reg          <= x_next;
      y_reg          <= y_next;
      dir_reg        <= dir_next;
      phase_reg      <= phase_next;
      moving_reg     <= moving_next;
      move_cnt_reg   <= move_cnt_next;
      anim_cnt_reg   <= anim_cnt_next;
      prev_state_reg <= state;
    end
  end

  assign player_x     = x_reg;
  assign player_y     = y_reg;
  assign player_state = {dir_reg, phase_reg};
  assign moving       = moving_reg;

endmodule
